dmem_resp: RTL
==============

Name: dmem_resp

Overview:
Registered data-memory responder for the RISC-V core's load/store interface (W_en, R_en, addr, RW_type, Wr_mem_data, Rd_mem_data). It sits on the memory side of that interface and owns a word-organised synchronous-read RAM. It performs byte and halfword lane selection, store byte-enables, and load sign/zero extension. A 2-state FSM gives loads a fixed 1-cycle response latency with a busy/valid handshake, so the core can stall on loads.

Parameters:
DEPTH_LOG2, 10, log2 of RAM depth in 32-bit words (default 1024 words = 4 KiB)
INIT_ZERO, 1, when 1 the RAM is zero-filled at simulation start (initial block only; reset never clears RAM)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
W_en  input  1  store request
R_en  input  1  load request
addr  input  32  byte address
RW_type  input  3  access type, RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
din  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
dout  output  32  load result, extended per RW_type
rd_valid  output  1  dout holds a completed load this cycle
busy  output  1  responder not accepting requests this cycle
err  output  1  one-cycle pulse: rejected request (misaligned, illegal RW_type, or W_en&R_en)

Behaviour:
- Reset: state=IDLE, dout=0, rd_valid=0, err=0, busy=0. RAM contents are kept. A reset asserted in RESP aborts the load; rd_valid=0 from the next cycle.
- States: IDLE, RESP. busy = (state==RESP), purely a decode of state.
- Word index = addr[DEPTH_LOG2+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*2^DEPTH_LOG2.
- Alignment: H/HU require addr[0]=0. W requires addr[1:0]=00. B/BU are always aligned.
- Illegal RW_type: 011, 110, 111 (both loads and stores). RW_type is ignored when W_en=R_en=0.
- Requests are sampled only in IDLE. In RESP, W_en and R_en are ignored: no write, no err.
- Store (IDLE, W_en=1, R_en=0, legal, aligned): the RAM is written at that edge.
  - Byte enables: B selects lane addr[1:0] and writes din[7:0] there. H selects lanes {addr[1],0} and {addr[1],1} and writes din[15:0]. W writes all four lanes.
  - Store behaviour for BU/HU: treated as illegal (err, no write).
  - No state change; busy stays 0; back-to-back stores every cycle are allowed.
- Load (IDLE, R_en=1, W_en=0, legal, aligned) at edge E0:
  - Registers the RAM word plus addr[1:0] and RW_type, then goes to RESP.
  - During the cycle after E0: rd_valid=1, busy=1, and dout = the selected lane, sign-extended (B/H) or zero-extended (BU/HU/W).
  - At the next edge: back to IDLE, rd_valid=0. dout holds its last value until the next load completes.
  - Load throughput is 1 per 2 cycles.
- Read-after-write: a store at edge E and a load accepted at E+1 to the same word return the new data. The RAM is read-first only within a single edge, which cannot happen because W_en and R_en are exclusive.
- Rejected request (IDLE, and W_en&R_en, or misaligned, or illegal RW_type):
  - No RAM change, no state change.
  - err=1 for exactly the next cycle.
  - A rejected load produces no rd_valid.
- err is registered: err is 0 whenever the previous cycle had no rejection.

Test Plan:
- Reset then idle: reset high 2 cycles → dout=0, rd_valid=0, busy=0, err=0; RAM word 0 keeps its INIT_ZERO value 0.
- SW addr=0x10 din=0x8081_F2A3, then LW 0x10 → rd_valid=1 one cycle after acceptance, dout=0x8081F2A3; busy=1 that same cycle only.
- Sub-word loads of the same word:
  - LB 0x11 → 0xFFFFFFF2; LBU 0x11 → 0x000000F2.
  - LH 0x12 → 0xFFFF8081; LHU 0x12 → 0x00008081.
  - LB 0x10 → 0xFFFFFFA3.
- SB 0x13 din=0x55, then SH 0x10 din=0x1234, then LW 0x10 → 0x55811234. Other lanes are untouched; both stores are issued on consecutive cycles with busy=0.
- Misaligned and illegal requests:
  - LW 0x12 → err pulse 1 cycle, no rd_valid.
  - SH 0x11 → err, word 0x10 unchanged.
  - W_en=R_en=1 → err, nothing written.
  - RW_type=011 load → err.
- Busy and reset interaction:
  - LW accepted, SW issued during RESP → store ignored (verify by readback), no err.
  - Reset asserted during RESP → rd_valid=0 next cycle, state IDLE.
  - Address 0x10+4·2^DEPTH_LOG2 aliases to word 0x10.

Source files
------------

// File: rtl/dmem_resp.sv
// dmem_resp: registered data-memory responder for the core load/store port.
// Owns a word-organised synchronous-read RAM. It handles byte and halfword
// lane selection, store byte-enables and load sign/zero extension. Loads
// complete with a fixed one-cycle latency, signalled by rd_valid and busy.
//
// Ports:
//   clk       clock; all state updates on the rising edge
//   reset     synchronous, active-high; the RAM contents are not cleared
//   W_en      store request
//   R_en      load request
//   addr      byte address; the upper bits wrap modulo the RAM size
//   RW_type   funct3 access type: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   din       right-aligned store data
//   dout      load result, extended according to RW_type; holds between loads
//   rd_valid  dout carries a completed load in this cycle
//   busy      requests are not accepted in this cycle
//   err       one-cycle pulse after a rejected request
module dmem_resp #(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int          INIT_ZERO  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        W_en,
    input  logic        R_en,
    input  logic [31:0] addr,
    input  logic [2:0]  RW_type,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        rd_valid,
    output logic        busy,
    output logic        err
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {IDLE, RESP} state_t;

    state_t state_q, state_d;

    // The initialiser only affects the power-up contents; reset never touches the RAM.
    logic [31:0] mem_q [DEPTH] = '{default: ((INIT_ZERO != 0) ? 32'h0 : 32'hxxxx_xxxx)};

    logic [31:0]           rdata_q;
    logic [1:0]            off_q;
    logic [2:0]            type_q;
    logic [31:0]           dout_q;
    logic                  err_q;

    logic [DEPTH_LOG2-1:0] widx;
    logic                  unused_addr;
    logic                  idle;
    logic                  type_ok;
    logic                  align_ok;
    logic                  do_store;
    logic                  do_load;
    logic                  reject;
    logic [3:0]            be;
    logic [31:0]           wdata;
    logic [7:0]            lane_b;
    logic [15:0]           lane_h;
    logic [31:0]           ext;

    assign widx        = addr[DEPTH_LOG2+1:2];
    assign unused_addr = ^addr[31:DEPTH_LOG2+2];
    assign idle        = (state_q == IDLE);

    // Access-type legality and natural alignment.
    always_comb begin
        type_ok  = 1'b0;
        align_ok = 1'b1;
        case (RW_type)
            3'b000, 3'b100: type_ok = 1'b1;
            3'b001, 3'b101: begin
                type_ok  = 1'b1;
                align_ok = ~addr[0];
            end
            3'b010: begin
                type_ok  = 1'b1;
                align_ok = (addr[1:0] == 2'b00);
            end
            default: ;
        endcase
    end

    // Unsigned variants (RW_type[2]=1) are meaningless for stores and are rejected.
    assign do_store = idle & ~reset & W_en & ~R_en & type_ok & ~RW_type[2] & align_ok;
    assign do_load  = idle & ~reset & R_en & ~W_en & type_ok & align_ok;
    assign reject   = idle & ~reset & (W_en | R_en) & ~do_store & ~do_load;

    // Store data is replicated across all lanes; the byte-enables pick the target lane(s).
    always_comb begin
        case (RW_type[1:0])
            2'b00: begin
                be    = 4'b0001 << addr[1:0];
                wdata = {4{din[7:0]}};
            end
            2'b01: begin
                be    = addr[1] ? 4'b1100 : 4'b0011;
                wdata = {2{din[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = din;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_store) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[widx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        if (do_load) begin
            rdata_q <= mem_q[widx];
        end
    end

    // Lane extraction from the registered word, using the latched offset and type.
    always_comb begin
        lane_b = rdata_q[8*off_q +: 8];
        lane_h = off_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (type_q)
            3'b000:  ext = {{24{lane_b[7]}}, lane_b};
            3'b100:  ext = {24'h0, lane_b};
            3'b001:  ext = {{16{lane_h[15]}}, lane_h};
            3'b101:  ext = {16'h0, lane_h};
            default: ext = rdata_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (do_load) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            dout_q  <= '0;
            off_q   <= '0;
            type_q  <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= reject;
            if (do_load) begin
                off_q  <= addr[1:0];
                type_q <= RW_type;
            end
            // Capture the result as the load completes so dout holds it afterwards.
            if (state_q == RESP) begin
                dout_q <= ext;
            end
        end
    end

    assign busy     = (state_q == RESP);
    assign rd_valid = (state_q == RESP);
    assign err      = err_q;
    assign dout     = (state_q == RESP) ? ext : dout_q;

endmodule
